// File: rtl/pipe_pkg.sv
// pipe_pkg: shared scoreboard entry type, defaults and forward-select width helper
package pipe_pkg;
    localparam int REG_ADDR_W_DEF = 4;
    localparam int REG_ADDR_W_MAX = 8;
    localparam int FWD_RF = 0;
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_W_MAX-1:0] dest;
        logic                      is_load;
    } sb_entry_t;
    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/sb_match.sv
// sb_match: youngest-slot-wins match of one source operand, yielding hit/stall/forward select
module sb_match import pipe_pkg::*; #(
    parameter int DEPTH = 3,
    parameter int FORWARD_EN = 1,
    parameter int LOAD_LAT = 2,
    parameter int RF_WRITE_THROUGH = 1,
    localparam int FSW = fwd_sel_w(DEPTH)
) (
    input  sb_entry_t                 slots [DEPTH],
    input  logic [REG_ADDR_W_MAX-1:0] src,
    input  logic                      en,
    output logic                      hit,
    output logic                      stall,
    output logic [FSW-1:0]            sel
);
    always_comb begin
        hit = 1'b0;
        stall = 1'b0;
        sel = FSW'(FWD_RF);
        // scanning oldest to youngest lets the youngest match overwrite older ones
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (en && slots[i].valid && slots[i].dest == src) begin
                hit = 1'b1;
                stall = (FORWARD_EN != 0) ? (slots[i].is_load && i < LOAD_LAT)
                                          : !(RF_WRITE_THROUGH != 0 && i == DEPTH - 1);
                sel = (FORWARD_EN == 0 || stall || (RF_WRITE_THROUGH != 0 && i == DEPTH - 1))
                      ? FSW'(FWD_RF) : FSW'(i + 1);
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes, drives stall and EX forward selects
module hazard_scoreboard import pipe_pkg::*; #(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH = 3,
    parameter int FORWARD_EN = 1,
    parameter int LOAD_LAT = 2,
    parameter int RF_WRITE_THROUGH = 1,
    localparam int FSW = fwd_sel_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wb_en,
    input  logic                  issue_is_load,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  has_two_src,
    input  logic                  flush,
    output logic                  stall,
    output logic [FSW-1:0]        fwd_sel1,
    output logic [FSW-1:0]        fwd_sel2,
    output logic [FSW-1:0]        inflight,
    output logic [31:0]           stall_cycles
);
    sb_entry_t   slot_q [DEPTH];
    sb_entry_t   slot_d [DEPTH];
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        hit1, hit2, stall1, stall2, ins;

    sb_match #(.DEPTH(DEPTH), .FORWARD_EN(FORWARD_EN), .LOAD_LAT(LOAD_LAT),
               .RF_WRITE_THROUGH(RF_WRITE_THROUGH)) u_m1 (
        .slots(slot_q), .src(REG_ADDR_W_MAX'(src1)), .en(issue_valid),
        .hit(hit1), .stall(stall1), .sel(fwd_sel1)
    );

    sb_match #(.DEPTH(DEPTH), .FORWARD_EN(FORWARD_EN), .LOAD_LAT(LOAD_LAT),
               .RF_WRITE_THROUGH(RF_WRITE_THROUGH)) u_m2 (
        .slots(slot_q), .src(REG_ADDR_W_MAX'(src2)), .en(issue_valid & has_two_src),
        .hit(hit2), .stall(stall2), .sel(fwd_sel2)
    );

    always_comb begin
        stall = issue_valid & ~flush & ((hit1 & stall1) | (hit2 & stall2));
        ins = issue_valid & issue_wb_en & ~stall & ~flush;
        slot_d[0] = ins ? sb_entry_t'{1'b1, REG_ADDR_W_MAX'(issue_dest), issue_is_load} : '0;
        for (int i = 1; i < DEPTH; i++) slot_d[i] = slot_q[i-1];
        inflight = '0;
        for (int i = 0; i < DEPTH; i++) inflight = inflight + FSW'(slot_q[i].valid);
        stall_cycles_d = (stall && stall_cycles_q != 32'hFFFF_FFFF) ? stall_cycles_q + 32'd1
                                                                   : stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            stall_cycles_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
endmodule
